// File: rtl/openip_fifo_pkg.sv
// Shared sizing helpers for the openip FIFO slice and its pointer sub-module.
// Pointer width is never below 1 bit so DEPTH=1 still has a legal index vector.
package openip_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/openip_fifo_ptr.sv
// Storage index that counts 0..DEPTH-1 and wraps by explicit compare, so DEPTH
// need not be a power of two. clr has priority over inc.
module openip_fifo_ptr
    import openip_fifo_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          inc,
    input  logic          clr,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_nxt;

    always_comb begin
        ptr_nxt = ptr;
        if (clr) begin
            ptr_nxt = '0;
        end else if (inc) begin
            ptr_nxt = (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/openip_fifo_slice.sv
// Valid/ready buffer of DEPTH entries with optional zero-latency fall-through and
// registered almost_full. Optional synchronous flush port: OPENIP_FIFO_FLUSH_EN.
module openip_fifo_slice
    import openip_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH   = 1,
    parameter type TYPE         = logic [DATA_WIDTH-1:0],
    parameter int  DEPTH        = 2,
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  AF_LEVEL     = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  TYPE                           w_data,
    output logic                          r_valid,
    input  logic                          r_ready,
    output TYPE                           r_data,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          almost_full
`ifdef OPENIP_FIFO_FLUSH_EN
   ,input  logic                          flush
`endif
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    // The DEPTH-1 default collapses to 0 for DEPTH=1; keep the flag meaningful.
    localparam int AF_EFF = (AF_LEVEL < 1) ? 1 : AF_LEVEL;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_EFF);

`ifndef OPENIP_FIFO_FLUSH_EN
    logic flush;
    assign flush = 1'b0;
`endif

    TYPE mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_nxt;
    logic          empty;
    logic          full;
    logic          bypass;
    logic          wr_hs;
    logic          rd_hs;
    logic          byp_beat;
    logic          push;
    logic          pop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_FULL);
    assign bypass = FALL_THROUGH && empty;

    // Ready and valid come from state (plus w_valid in bypass) only; r_ready never reaches w_ready.
    assign w_ready = !full && !flush;
    assign r_valid = (bypass ? w_valid : !empty) && !flush;
    assign r_data  = bypass ? w_data : mem[rd_ptr];

    assign wr_hs    = w_valid && w_ready;
    assign rd_hs    = r_valid && r_ready;
    assign byp_beat = bypass && wr_hs && rd_hs;
    assign push     = wr_hs && !byp_beat;
    assign pop      = rd_hs && !byp_beat;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_nxt;
            almost_full <= (count_nxt >= CNT_AF);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= w_data;
        end
    end

    openip_fifo_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_wr_ptr (
        .clk  (clk),
        .rstn (rstn),
        .inc  (push),
        .clr  (flush),
        .ptr  (wr_ptr)
    );

    openip_fifo_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_rd_ptr (
        .clk  (clk),
        .rstn (rstn),
        .inc  (pop),
        .clr  (flush),
        .ptr  (rd_ptr)
    );

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rstn) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rstn) !(pop && !r_valid));

endmodule

// File: tb/tb_openip_fifo_slice.sv
// Directed bench for openip_fifo_slice: four instances cover DEPTH 4/2/3 registered
// and DEPTH 2 fall-through; flush scenario only when OPENIP_FIFO_FLUSH_EN is defined.
module tb_openip_fifo_slice;

    logic clk;
    logic rstn;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: DEPTH=4 registered
    logic       a_wv, a_wr, a_rv, a_rr, a_af, a_flush;
    logic [7:0] a_wd, a_rd;
    logic [2:0] a_cnt;
    // B: DEPTH=2 registered
    logic       b_wv, b_wr, b_rv, b_rr, b_af;
    logic [7:0] b_wd, b_rd;
    logic [1:0] b_cnt;
    // C: DEPTH=3 registered
    logic       c_wv, c_wr, c_rv, c_rr, c_af;
    logic [7:0] c_wd, c_rd;
    logic [1:0] c_cnt;
    // D: DEPTH=2 fall-through
    logic       d_wv, d_wr, d_rv, d_rr, d_af;
    logic [7:0] d_wd, d_rd;
    logic [1:0] d_cnt;

    openip_fifo_slice #(.DATA_WIDTH(8), .DEPTH(4), .FALL_THROUGH(1'b0)) u_a (
        .clk(clk), .rstn(rstn), .w_valid(a_wv), .w_ready(a_wr), .w_data(a_wd),
        .r_valid(a_rv), .r_ready(a_rr), .r_data(a_rd), .count(a_cnt), .almost_full(a_af)
`ifdef OPENIP_FIFO_FLUSH_EN
       ,.flush(a_flush)
`endif
    );

    openip_fifo_slice #(.DATA_WIDTH(8), .DEPTH(2), .FALL_THROUGH(1'b0)) u_b (
        .clk(clk), .rstn(rstn), .w_valid(b_wv), .w_ready(b_wr), .w_data(b_wd),
        .r_valid(b_rv), .r_ready(b_rr), .r_data(b_rd), .count(b_cnt), .almost_full(b_af)
`ifdef OPENIP_FIFO_FLUSH_EN
       ,.flush(1'b0)
`endif
    );

    openip_fifo_slice #(.DATA_WIDTH(8), .DEPTH(3), .FALL_THROUGH(1'b0)) u_c (
        .clk(clk), .rstn(rstn), .w_valid(c_wv), .w_ready(c_wr), .w_data(c_wd),
        .r_valid(c_rv), .r_ready(c_rr), .r_data(c_rd), .count(c_cnt), .almost_full(c_af)
`ifdef OPENIP_FIFO_FLUSH_EN
       ,.flush(1'b0)
`endif
    );

    openip_fifo_slice #(.DATA_WIDTH(8), .DEPTH(2), .FALL_THROUGH(1'b1)) u_d (
        .clk(clk), .rstn(rstn), .w_valid(d_wv), .w_ready(d_wr), .w_data(d_wd),
        .r_valid(d_rv), .r_ready(d_rr), .r_data(d_rd), .count(d_cnt), .almost_full(d_af)
`ifdef OPENIP_FIFO_FLUSH_EN
       ,.flush(1'b0)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr_n, rd_n, last_c, maxc;
        logic hs_w, hs_r;

        rstn = 1'b0;
        a_wv = 0; a_rr = 0; a_wd = 0; a_flush = 0;
        b_wv = 0; b_rr = 0; b_wd = 0;
        c_wv = 0; c_rr = 0; c_wd = 0;
        d_wv = 0; d_rr = 0; d_wd = 0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_count", 32'(a_cnt), 32'd0);
        check_val("rst_r_valid", 32'(a_rv), 32'd0);
        check_val("rst_w_ready", 32'(a_wr), 32'd1);
        check_val("rst_af", 32'(a_af), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc();

        // 1: fill DEPTH=4 then drain
        for (int i = 0; i < 4; i++) begin
            a_wv = 1'b1;
            a_wd = 8'(8'hA + i);
            cyc();
            check_val($sformatf("t1_count_w%0d", i), 32'(a_cnt), 32'(i + 1));
            check_val($sformatf("t1_af_w%0d", i), 32'(a_af), (i >= 2) ? 32'd1 : 32'd0);
        end
        check_val("t1_w_ready_full", 32'(a_wr), 32'd0);
        a_wv = 1'b0;
        a_rr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t1_r_valid_%0d", i), 32'(a_rv), 32'd1);
            check_val($sformatf("t1_r_data_%0d", i), 32'(a_rd), 32'(8'hA + i));
            cyc();
        end
        a_rr = 1'b0;
        check_val("t1_count_end", 32'(a_cnt), 32'd0);
        check_val("t1_r_valid_end", 32'(a_rv), 32'd0);
        check_val("t1_af_end", 32'(a_af), 32'd0);

        // 2: DEPTH=2 streaming, one beat per cycle after one cycle latency
        b_rr = 1'b1;
        wr_n = 0; rd_n = 0; last_c = -1; maxc = 0;
        for (int c = 0; c < 300 && rd_n < 100; c++) begin
            b_wv = (wr_n < 100);
            b_wd = 8'(wr_n);
            @(negedge clk);
            if (int'(b_cnt) > maxc) maxc = int'(b_cnt);
            hs_w = b_wv && b_wr;
            hs_r = b_rv && b_rr;
            if (hs_r) begin
                check_val("t2_data", 32'(b_rd), 32'(8'(rd_n)));
                rd_n++;
                last_c = c;
            end
            cyc();
            if (hs_w) wr_n++;
        end
        b_wv = 1'b0;
        b_rr = 1'b0;
        check_val("t2_beats", 32'(rd_n), 32'd100);
        check_val("t2_last_cycle", 32'(last_c), 32'd100);
        check_val("t2_max_count", 32'(maxc), 32'd1);

        // 3: DEPTH=3 with stalls on both sides
        wr_n = 0; rd_n = 0; maxc = 0;
        for (int c = 0; c < 200 && rd_n < 10; c++) begin
            c_wv = (wr_n < 10) && (c % 4 != 3);
            c_rr = (c >= 4) && (c % 3 != 0);
            c_wd = 8'(8'h30 + wr_n);
            @(negedge clk);
            if (int'(c_cnt) > maxc) maxc = int'(c_cnt);
            hs_w = c_wv && c_wr;
            hs_r = c_rv && c_rr;
            if (hs_r) begin
                check_val("t3_data", 32'(c_rd), 32'(8'h30 + rd_n));
                rd_n++;
            end
            cyc();
            if (hs_w) wr_n++;
        end
        c_wv = 1'b0;
        c_rr = 1'b0;
        check_val("t3_beats", 32'(rd_n), 32'd10);
        check_val("t3_max_count", 32'(maxc), 32'd3);
        check_val("t3_count_end", 32'(c_cnt), 32'd0);

        // 4: fall-through bypass when empty, then store when reader stalls
        d_wv = 1'b1; d_wd = 8'h05; d_rr = 1'b1;
        #1;
        check_val("t4_byp_r_valid", 32'(d_rv), 32'd1);
        check_val("t4_byp_r_data", 32'(d_rd), 32'h05);
        check_val("t4_byp_count", 32'(d_cnt), 32'd0);
        cyc();
        check_val("t4_count_after_byp", 32'(d_cnt), 32'd0);
        d_rr = 1'b0; d_wd = 8'h06;
        #1;
        check_val("t4_ft_r_data", 32'(d_rd), 32'h06);
        cyc();
        d_wv = 1'b0;
        #1;
        check_val("t4_stored_count", 32'(d_cnt), 32'd1);
        check_val("t4_stored_r_valid", 32'(d_rv), 32'd1);
        check_val("t4_stored_r_data", 32'(d_rd), 32'h06);
        d_rr = 1'b1;
        cyc();
        d_rr = 1'b0;
        check_val("t4_drained", 32'(d_cnt), 32'd0);

        // 5: async reset with entries held
        a_wv = 1'b1; a_wd = 8'h11;
        cyc();
        a_wd = 8'h22;
        cyc();
        a_wv = 1'b0;
        check_val("t5_count_pre", 32'(a_cnt), 32'd2);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_val("t5_count", 32'(a_cnt), 32'd0);
        check_val("t5_r_valid", 32'(a_rv), 32'd0);
        check_val("t5_w_ready", 32'(a_wr), 32'd1);
        #2;
        rstn = 1'b1;
        cyc();

`ifdef OPENIP_FIFO_FLUSH_EN
        // 6: flush drops contents and the concurrent write
        for (int i = 0; i < 3; i++) begin
            a_wv = 1'b1;
            a_wd = 8'(8'h61 + i);
            cyc();
        end
        a_wv = 1'b0;
        check_val("t6_count_pre", 32'(a_cnt), 32'd3);
        a_flush = 1'b1; a_wv = 1'b1; a_wd = 8'h77;
        #1;
        check_val("t6_w_ready", 32'(a_wr), 32'd0);
        check_val("t6_r_valid", 32'(a_rv), 32'd0);
        cyc();
        a_flush = 1'b0; a_wv = 1'b0;
        #1;
        check_val("t6_count", 32'(a_cnt), 32'd0);
        check_val("t6_af", 32'(a_af), 32'd0);
        check_val("t6_r_valid_after", 32'(a_rv), 32'd0);
        a_wv = 1'b1; a_wd = 8'h55;
        cyc();
        a_wv = 1'b0;
        check_val("t6_new_count", 32'(a_cnt), 32'd1);
        check_val("t6_new_data", 32'(a_rd), 32'h55);
        a_rr = 1'b1;
        cyc();
        a_rr = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
